// File: rtl/ulpi_ctl_ext.sv
// ULPI link-side controller: RX CMD tracking, receive byte stream, and a PHY register
// port with immediate and extended (0x2F) addressing, abort retries and a watchdog.
module ulpi_ctl_ext #(
    parameter bit          EXT_ADDR_EN    = 1'b1,
    parameter int unsigned RETRY_MAX      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic       ulpi_clk,
    input  logic       ulpi_rst,
    input  logic       ulpi_dir,
    input  logic       ulpi_nxt,
    output logic       ulpi_stp,
    input  logic [7:0] ulpi_data_in,
    output logic [7:0] ulpi_data_out,
    output logic [1:0] line_state,
    output logic [1:0] vbus_state,
    output logic       rx_active,
    output logic       rx_error,
    output logic       host_disconnect,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       reg_en,
    input  logic       reg_we,
    input  logic [7:0] reg_addr,
    input  logic [7:0] reg_din,
    output logic [7:0] reg_dout,
    output logic       reg_rdy,
    output logic       reg_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TimeoutVal = TW'(TIMEOUT_CYCLES);
    localparam logic [3:0]    RetryMax   = 4'(RETRY_MAX);

    typedef enum logic [2:0] {
        StIdle, StCmd, StExt, StWrData, StRdTurn, StRdData, StDone
    } state_e;

    state_e        state_q, state_d;
    logic          dir_q;
    logic          we_q, we_d;
    logic          ext_q, ext_d;
    logic          illegal_q, illegal_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    din_q, din_d;
    logic [3:0]    retry_q, retry_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          err_q, err_d;
    logic          stp_q, stp_d;
    logic [7:0]    dout_q, dout_d;

    logic [1:0]    line_state_q, vbus_state_q;
    logic          rx_active_q, rx_error_q, host_disc_q;
    logic [7:0]    rx_data_q;
    logic          rx_valid_q;

    logic turnaround;
    logic dir_rise;
    logic abort;
    logic timeout;
    logic [7:0] cmd_byte;

    assign turnaround = ulpi_dir ^ dir_q;
    assign dir_rise   = ulpi_dir & ~dir_q;
    assign cmd_byte   = {(we_q ? 2'b10 : 2'b11), (ext_q ? 6'h2F : addr_q[5:0])};

    // Register-access FSM next state, counters and latched request.
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        ext_d     = ext_q;
        illegal_d = illegal_q;
        addr_d    = addr_q;
        din_d     = din_q;
        retry_d   = retry_q;
        timer_d   = timer_q;
        err_d     = err_q;
        stp_d     = 1'b0;
        dout_d    = dout_q;
        abort     = 1'b0;
        timeout   = 1'b0;

        if (state_q != StIdle && state_q != StDone) begin
            timer_d = timer_q + TW'(1);
            timeout = (timer_d == TimeoutVal);
        end

        case (state_q)
            StIdle: begin
                timer_d = '0;
                if (reg_en) begin
                    we_d      = reg_we;
                    addr_d    = reg_addr;
                    din_d     = reg_din;
                    ext_d     = EXT_ADDR_EN && (reg_addr > 8'h2E);
                    illegal_d = !EXT_ADDR_EN && (reg_addr > 8'h3F);
                    retry_d   = '0;
                    err_d     = 1'b0;
                    state_d   = StCmd;
                end
            end
            StCmd: begin
                if (illegal_q) begin
                    // No bus activity for an address this build cannot reach.
                    err_d   = 1'b1;
                    state_d = StDone;
                end else if (dir_rise) begin
                    abort = 1'b1;
                end else if (!turnaround && !ulpi_dir && ulpi_nxt) begin
                    state_d = ext_q ? StExt : (we_q ? StWrData : StRdTurn);
                end
            end
            StExt: begin
                if (dir_rise) begin
                    abort = 1'b1;
                end else if (!ulpi_dir && ulpi_nxt) begin
                    state_d = we_q ? StWrData : StRdTurn;
                end
            end
            StWrData: begin
                if (dir_rise) begin
                    abort = 1'b1;
                end else if (!ulpi_dir && ulpi_nxt) begin
                    stp_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StRdTurn: begin
                if (turnaround && ulpi_dir) begin
                    // nxt with the turnaround means the PHY started a receive instead.
                    if (ulpi_nxt) abort = 1'b1;
                    else          state_d = StRdData;
                end
            end
            StRdData: begin
                if (rx_active_q || ulpi_nxt) begin
                    abort = 1'b1;
                end else begin
                    dout_d  = ulpi_data_in;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // After an abort CMD waits out dir before re-driving the command byte.
        if (abort) begin
            if (retry_q < RetryMax) begin
                retry_d = retry_q + 4'd1;
                state_d = StCmd;
            end else begin
                err_d   = 1'b1;
                state_d = StDone;
            end
        end

        if (timeout) begin
            state_d = StDone;
            err_d   = 1'b1;
            stp_d   = 1'b0;
            dout_d  = dout_q;
        end
    end

    // Register-access state and request registers.
    always_ff @(posedge ulpi_clk) begin
        if (ulpi_rst) begin
            state_q   <= StIdle;
            dir_q     <= 1'b0;
            we_q      <= 1'b0;
            ext_q     <= 1'b0;
            illegal_q <= 1'b0;
            addr_q    <= 8'h00;
            din_q     <= 8'h00;
            retry_q   <= '0;
            timer_q   <= '0;
            err_q     <= 1'b0;
            stp_q     <= 1'b0;
            dout_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            dir_q     <= ulpi_dir;
            we_q      <= we_d;
            ext_q     <= ext_d;
            illegal_q <= illegal_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            retry_q   <= retry_d;
            timer_q   <= timer_d;
            err_q     <= err_d;
            stp_q     <= stp_d;
            dout_q    <= dout_d;
        end
    end

    // RX CMD status and receive byte stream.
    always_ff @(posedge ulpi_clk) begin
        if (ulpi_rst) begin
            line_state_q <= 2'b00;
            vbus_state_q <= 2'b00;
            rx_active_q  <= 1'b0;
            rx_error_q   <= 1'b0;
            host_disc_q  <= 1'b0;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
        end else begin
            rx_valid_q <= !turnaround && ulpi_dir && ulpi_nxt && rx_active_q;
            if (!turnaround && ulpi_dir && ulpi_nxt && rx_active_q) begin
                rx_data_q <= ulpi_data_in;
            end
            if (turnaround && !ulpi_dir) begin
                rx_active_q <= 1'b0;
            end else if (turnaround && ulpi_dir && ulpi_nxt) begin
                rx_active_q <= 1'b1;
            end else if (!turnaround && ulpi_dir && !ulpi_nxt && state_q != StRdData) begin
                line_state_q <= ulpi_data_in[1:0];
                vbus_state_q <= ulpi_data_in[3:2];
                rx_active_q  <= ulpi_data_in[4];
                rx_error_q   <= (ulpi_data_in[5:4] == 2'b11);
                host_disc_q  <= (ulpi_data_in[5:4] == 2'b10);
            end
        end
    end

    // Link data bus: released to 0x00 whenever the PHY owns it.
    always_comb begin
        ulpi_data_out = 8'h00;
        if (!ulpi_dir) begin
            case (state_q)
                StCmd:    ulpi_data_out = illegal_q ? 8'h00 : cmd_byte;
                StExt:    ulpi_data_out = addr_q;
                StWrData: ulpi_data_out = din_q;
                default:  ulpi_data_out = 8'h00;
            endcase
        end
    end

    assign ulpi_stp        = stp_q;
    assign line_state      = line_state_q;
    assign vbus_state      = vbus_state_q;
    assign rx_active       = rx_active_q;
    assign rx_error        = rx_error_q;
    assign host_disconnect = host_disc_q;
    assign rx_data         = rx_data_q;
    assign rx_valid        = rx_valid_q;
    assign reg_dout        = dout_q;
    assign reg_rdy         = (state_q == StDone);
    assign reg_err         = (state_q == StDone) && err_q;

endmodule

// File: tb/tb_ulpi_ctl_ext.sv
// Directed bench for ulpi_ctl_ext: instance A (extended addressing, 3 retries) and
// instance B (immediate only, 1 retry) share stimulus; both use a 32-cycle watchdog.
module tb_ulpi_ctl_ext;

    logic       ulpi_clk = 1'b0;
    logic       ulpi_rst = 1'b1;
    logic       ulpi_dir = 1'b0;
    logic       ulpi_nxt = 1'b0;
    logic [7:0] ulpi_data_in = 8'h00;
    logic       reg_en = 1'b0;
    logic       reg_we = 1'b0;
    logic [7:0] reg_addr = 8'h00;
    logic [7:0] reg_din = 8'h00;

    logic       a_stp, a_rxa, a_rxerr, a_disc, a_rxv, a_rdy, a_err;
    logic [7:0] a_data, a_rxd, a_dout;
    logic [1:0] a_ls, a_vb;
    logic       b_stp, b_rxa, b_rxerr, b_disc, b_rxv, b_rdy, b_err;
    logic [7:0] b_data, b_rxd, b_dout;
    logic [1:0] b_ls, b_vb;

    int checks = 0;
    int errors = 0;

    always #5 ulpi_clk = ~ulpi_clk;

    ulpi_ctl_ext #(.EXT_ADDR_EN(1'b1), .RETRY_MAX(3), .TIMEOUT_CYCLES(32)) u_dut_a (
        .ulpi_clk(ulpi_clk), .ulpi_rst(ulpi_rst), .ulpi_dir(ulpi_dir), .ulpi_nxt(ulpi_nxt),
        .ulpi_stp(a_stp), .ulpi_data_in(ulpi_data_in), .ulpi_data_out(a_data),
        .line_state(a_ls), .vbus_state(a_vb), .rx_active(a_rxa), .rx_error(a_rxerr),
        .host_disconnect(a_disc), .rx_data(a_rxd), .rx_valid(a_rxv), .reg_en(reg_en),
        .reg_we(reg_we), .reg_addr(reg_addr), .reg_din(reg_din), .reg_dout(a_dout),
        .reg_rdy(a_rdy), .reg_err(a_err)
    );

    ulpi_ctl_ext #(.EXT_ADDR_EN(1'b0), .RETRY_MAX(1), .TIMEOUT_CYCLES(32)) u_dut_b (
        .ulpi_clk(ulpi_clk), .ulpi_rst(ulpi_rst), .ulpi_dir(ulpi_dir), .ulpi_nxt(ulpi_nxt),
        .ulpi_stp(b_stp), .ulpi_data_in(ulpi_data_in), .ulpi_data_out(b_data),
        .line_state(b_ls), .vbus_state(b_vb), .rx_active(b_rxa), .rx_error(b_rxerr),
        .host_disconnect(b_disc), .rx_data(b_rxd), .rx_valid(b_rxv), .reg_en(reg_en),
        .reg_we(reg_we), .reg_addr(reg_addr), .reg_din(reg_din), .reg_dout(b_dout),
        .reg_rdy(b_rdy), .reg_err(b_err)
    );

    typedef struct packed {
        logic       dir;
        logic       nxt;
        logic [7:0] din;
        logic       en;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wd;
        logic [7:0] e_data;
        logic       e_stp;
        logic       e_rdy;
        logic       e_err;
        logic       e_rxv;
        logic [7:0] e_rxd;
        logic       e_rxa;
        logic [1:0] e_ls;
        logic [1:0] e_vb;
        logic       e_disc;
        logic       e_rxerr;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic d, input logic n, input logic [7:0] di, input logic en,
                         input logic we, input logic [7:0] ad, input logic [7:0] wd);
        ulpi_dir     = d;
        ulpi_nxt     = n;
        ulpi_data_in = di;
        reg_en       = en;
        reg_we       = we;
        reg_addr     = ad;
        reg_din      = wd;
    endtask

    task automatic to_mid();
        @(negedge ulpi_clk);
    endtask

    task automatic to_next();
        @(posedge ulpi_clk);
        #1;
    endtask

    initial begin
        int runs;
        logic prev85;

        // dir nxt din en we addr wd | data stp rdy err rxv rxd rxa ls vb disc rxerr
        vecs[0]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h0A, 8'h45,
                     8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00,
                     8'h8A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00,
                     8'h45, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00,
                     8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00,
                     8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00,
                     8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 8'h1D, 1'b0, 1'b0, 8'h00, 8'h00,
                     8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, 8'h00, 8'h00,
                     8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'd1, 2'd3, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00,
                     8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b1, 2'd1, 2'd3, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00,
                     8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 2'd1, 2'd3, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00,
                     8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0, 2'd1, 2'd3, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00,
                     8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0, 2'd1, 2'd3, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 8'h26, 1'b0, 1'b0, 8'h00, 8'h00,
                     8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0, 2'd1, 2'd3, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 8'h3B, 1'b0, 1'b0, 8'h00, 8'h00,
                     8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0, 2'd2, 2'd1, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00,
                     8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 2'd3, 2'd2, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00,
                     8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0, 2'd3, 2'd2, 1'b0, 1'b1};

        // Reset values
        repeat (3) @(posedge ulpi_clk);
        #1;
        to_mid();
        chk("rst stp", a_stp, 0);
        chk("rst data_out", a_data, 0);
        chk("rst line/vbus", {a_ls, a_vb}, 0);
        chk("rst rx flags", {a_rxa, a_rxerr, a_disc, a_rxv}, 0);
        chk("rst rx_data", a_rxd, 0);
        chk("rst rdy/err", {a_rdy, a_err}, 0);
        chk("rst reg_dout", a_dout, 0);
        chk("rst B outs lo", {b_stp, b_data, b_ls, b_vb, b_rxa, b_rxerr, b_disc, b_rxv}, 0);
        chk("rst B outs hi", {b_rxd, b_rdy, b_err, b_dout}, 0);
        to_next();
        ulpi_rst = 1'b0;
        to_next();

        // Immediate write followed by RX CMD / packet traffic
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].dir, vecs[i].nxt, vecs[i].din, vecs[i].en, vecs[i].we,
                  vecs[i].addr, vecs[i].wd);
            to_mid();
            chk($sformatf("v%0d data_out", i), a_data, vecs[i].e_data);
            chk($sformatf("v%0d stp", i), a_stp, vecs[i].e_stp);
            chk($sformatf("v%0d rdy/err", i), {a_rdy, a_err}, {vecs[i].e_rdy, vecs[i].e_err});
            chk($sformatf("v%0d rx_valid", i), a_rxv, vecs[i].e_rxv);
            chk($sformatf("v%0d rx_data", i), a_rxd, vecs[i].e_rxd);
            chk($sformatf("v%0d rx_active", i), a_rxa, vecs[i].e_rxa);
            chk($sformatf("v%0d line/vbus", i), {a_ls, a_vb}, {vecs[i].e_ls, vecs[i].e_vb});
            chk($sformatf("v%0d disc/rxerr", i), {a_disc, a_rxerr},
                {vecs[i].e_disc, vecs[i].e_rxerr});
            to_next();
        end

        // Extended read of 0x81 on A; B rejects the address with no bus activity
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h81, 8'h00);
        to_mid(); chk("xrd c0 data", a_data, 8'h00); to_next();
        drive(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        to_mid(); chk("xrd c1 cmd", a_data, 8'hEF); chk("xrd c1 B data", b_data, 0); to_next();
        to_mid(); chk("xrd c2 addr", a_data, 8'h81);
        chk("xrd c2 B rdy/err", {b_rdy, b_err}, 2'b11); chk("xrd c2 B data", b_data, 0);
        to_next();
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        to_mid(); chk("xrd c3 data", a_data, 8'h00); chk("xrd c3 rdy", a_rdy, 0); to_next();
        drive(1'b1, 1'b0, 8'h5C, 1'b0, 1'b0, 8'h00, 8'h00);
        to_mid(); chk("xrd c4 rdy", a_rdy, 0); to_next();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        to_mid(); chk("xrd c5 rdy/err", {a_rdy, a_err}, 2'b10);
        chk("xrd c5 dout", a_dout, 8'h5C); chk("xrd c5 line/vbus", {a_ls, a_vb}, 4'b1110);
        to_next();
        to_mid(); chk("xrd c6 rdy", a_rdy, 0); chk("xrd c6 dout", a_dout, 8'h5C); to_next();

        // Two dir-aborts during CMD: A retries to success, B exhausts its single retry
        runs = 0;
        prev85 = 1'b0;
        for (int c = 0; c < 13; c++) begin
            logic d;
            logic n;
            d = (c == 2 || c == 3 || c == 6 || c == 7);
            n = (c == 9 || c == 10);
            drive(d, n, 8'h00, (c == 0), 1'b1, 8'h05, 8'h3C);
            to_mid();
            if (a_data == 8'h85 && !prev85) runs++;
            prev85 = (a_data == 8'h85);
            chk($sformatf("retry c%0d A rdy", c), a_rdy, (c == 11));
            chk($sformatf("retry c%0d A stp", c), a_stp, (c == 11));
            chk($sformatf("retry c%0d A err", c), a_err, 0);
            chk($sformatf("retry c%0d B rdy/err", c), {b_rdy, b_err}, {2{c == 7}});
            if (c == 10) chk("retry c10 A wdata", a_data, 8'h3C);
            to_next();
        end
        chk("retry cmd attempts", runs, 3);

        // Stuck access: A times out 32 cycles after leaving IDLE; B rejects 0x90 at cycle 2
        for (int c = 0; c < 41; c++) begin
            drive(1'b0, 1'b0, 8'h00, (c == 0), 1'b1, 8'h90, 8'h00);
            to_mid();
            chk($sformatf("wdog c%0d A rdy/err", c), {a_rdy, a_err}, {2{c == 33}});
            chk($sformatf("wdog c%0d A stp", c), a_stp, 0);
            chk($sformatf("wdog c%0d A data", c), a_data,
                (c >= 1 && c <= 32) ? 8'hAF : 8'h00);
            chk($sformatf("wdog c%0d B rdy/err", c), {b_rdy, b_err}, {2{c == 2}});
            chk($sformatf("wdog c%0d B data", c), b_data, 0);
            to_next();
        end

        // Reset mid-access discards the write without a completion pulse
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h0A, 8'h45);
        to_mid(); to_next();
        drive(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        ulpi_rst = 1'b1;
        to_mid(); chk("mrst c1 cmd", a_data, 8'h8A); to_next();
        ulpi_rst = 1'b0;
        for (int c = 2; c < 7; c++) begin
            to_mid();
            chk($sformatf("mrst c%0d data", c), a_data, 0);
            chk($sformatf("mrst c%0d stp/rdy", c), {a_stp, a_rdy}, 0);
            to_next();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
